// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit: opcode constants,
// the 4-bit controller state enum, datapath mux/ALU encodings and a helper
// that maps an I-type ALU opcode onto its ALUOp code.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC_R  = 4'd6,
    ST_ALUWB_R = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_JUMP    = 4'd9,
    ST_JAL     = 4'd10,
    ST_EXEC_I  = 4'd11,
    ST_ALUWB_I = 4'd12
  } state_t;

  // ALUOp
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // RegDst
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // MemToReg
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operation for the immediate-ALU group; addi (and anything else) adds.
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_control_fsm_if
// Bundle between the multicycle control unit and the datapath/memory side.
//   opcode, mem_ready            : datapath -> controller
//   IorD .. PCWriteBne           : controller -> datapath mux selects/enables
//   illegal_op, mem_timeout      : controller status pulses
//   retired_count, stall_count   : performance counters (CNT_W bits)
// modport master : the controller
// modport slave  : the datapath / memory side
// ---------------------------------------------------------------------------
interface mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             IorD;
  logic             IRWrite;
  logic [1:0]       RegDst;
  logic             MemRead;
  logic             MemWrite;
  logic [1:0]       MemToReg;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic             RegWrite;
  logic [1:0]       PCSource;
  logic             PCWrite;
  logic             PCWriteBeq;
  logic             PCWriteBne;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] retired_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    input  opcode, mem_ready,
    output IorD, IRWrite, RegDst, MemRead, MemWrite, MemToReg, ALUSrcA,
           ALUSrcB, ALUOp, RegWrite, PCSource, PCWrite, PCWriteBeq,
           PCWriteBne, illegal_op, mem_timeout, retired_count, stall_count
  );

  modport slave (
    output opcode, mem_ready,
    input  IorD, IRWrite, RegDst, MemRead, MemWrite, MemToReg, ALUSrcA,
           ALUSrcB, ALUOp, RegWrite, PCSource, PCWrite, PCWriteBeq,
           PCWriteBne, illegal_op, mem_timeout, retired_count, stall_count
  );
endinterface

// File: rtl/mc_wait_timer.sv
// ---------------------------------------------------------------------------
// mc_wait_timer
// Counts consecutive memory wait cycles and flags the cycle in which the
// wait limit is reached.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart the count (no wait in progress)
//   waiting      : the controller is in a memory state with mem_ready=0
//   expired      : this wait cycle is the WAIT_LIMIT-th in a row
// WAIT_LIMIT=0 disables the timeout (expired stays 0).
// ---------------------------------------------------------------------------
module mc_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);
  localparam int CW       = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam int LIMIT_M1 = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LIMIT_M1);

  logic [CW-1:0] count;

  // The first wait cycle sees count=0, so the limit cycle sees WAIT_LIMIT-1.
  assign expired = (WAIT_LIMIT != 0) && waiting && (count == LAST);

  // An expiry forces FETCH, so the count restarts even if FETCH is re-entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Multicycle MIPS control unit with memory ready/wait handshake, wait
// timeout, illegal-opcode reporting and optional performance counters.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (state -> FETCH)
//   bus     : mc_control_fsm_if.master (opcode/mem_ready in, datapath
//             controls, illegal_op/mem_timeout pulses, counters out)
// Parameters: WAIT_LIMIT (0 disables timeout), CNT_W (counter width).
// Optional feature macro: MC_CTRL_PERF_EN enables retired_count/stall_count;
// without it both counters are tied to 0.
// ---------------------------------------------------------------------------
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  mc_control_fsm_if.master  bus
);

  state_t state, state_nxt;
  logic   mem_state, waiting, wait_clear, expired;

  assign mem_state  = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);
  assign waiting    = mem_state && !bus.mem_ready;
  assign wait_clear = !waiting;

  mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wait_clear),
    .waiting (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_FETCH;
    else          state <= state_nxt;
  end

  // Controls are decoded from the current state (plus mem_ready in FETCH),
  // so they take effect in the same cycle the state is entered.
  always_comb begin
    state_nxt       = state;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = REGDST_RT;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemToReg    = M2R_ALUOUT;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_B;
    bus.ALUOp       = ALU_ADD;
    bus.RegWrite    = 1'b0;
    bus.PCSource    = PCSRC_ALU;
    bus.PCWrite     = 1'b0;
    bus.PCWriteBeq  = 1'b0;
    bus.PCWriteBne  = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.mem_timeout = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready) begin
          state_nxt = ST_DECODE;
        end else if (expired) begin
          bus.mem_timeout = 1'b1;
          state_nxt       = ST_FETCH;
        end
      end
      ST_DECODE: begin
        bus.ALUSrcB = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_RTYPE:                          state_nxt = ST_EXEC_R;
          OP_LW, OP_SW:                      state_nxt = ST_MEMADR;
          OP_BEQ, OP_BNE:                    state_nxt = ST_BRANCH;
          OP_J:                              state_nxt = ST_JUMP;
          OP_JAL:                            state_nxt = ST_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nxt = ST_EXEC_I;
          default: begin
            bus.illegal_op = 1'b1;
            state_nxt      = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        state_nxt   = (bus.opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
        if (bus.mem_ready) begin
          state_nxt = ST_MEMWB;
        end else if (expired) begin
          bus.mem_timeout = 1'b1;
          state_nxt       = ST_FETCH;
        end
      end
      ST_MEMWB: begin
        bus.MemToReg = M2R_MDR;
        bus.RegWrite = 1'b1;
        state_nxt    = ST_FETCH;
      end
      ST_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.mem_ready) begin
          state_nxt = ST_FETCH;
        end else if (expired) begin
          bus.mem_timeout = 1'b1;
          state_nxt       = ST_FETCH;
        end
      end
      ST_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALU_FUNCT;
        state_nxt   = ST_ALUWB_R;
      end
      ST_ALUWB_R: begin
        bus.RegDst   = REGDST_RD;
        bus.RegWrite = 1'b1;
        state_nxt    = ST_FETCH;
      end
      ST_BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUOp      = ALU_SUB;
        bus.PCSource   = PCSRC_ALUOUT;
        bus.PCWriteBeq = (bus.opcode == OP_BEQ);
        bus.PCWriteBne = (bus.opcode == OP_BNE);
        state_nxt      = ST_FETCH;
      end
      ST_JUMP: begin
        bus.PCSource = PCSRC_JUMP;
        bus.PCWrite  = 1'b1;
        state_nxt    = ST_FETCH;
      end
      ST_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        bus.PCSource = PCSRC_JUMP;
        bus.PCWrite  = 1'b1;
        bus.RegDst   = REGDST_RA;
        bus.MemToReg = M2R_PC;
        bus.RegWrite = 1'b1;
        state_nxt    = ST_FETCH;
      end
      ST_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = imm_alu_op(bus.opcode);
        state_nxt   = ST_ALUWB_I;
      end
      ST_ALUWB_I: begin
        // ALUOp stays on the immediate operation while ALUOut is written back;
        // the IR (and so opcode) is stable until the next FETCH completes.
        bus.ALUOp    = imm_alu_op(bus.opcode);
        bus.RegWrite = 1'b1;
        state_nxt    = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  logic             retire;
  logic [CNT_W-1:0] retired_q, stall_q;

  // Final cycle of a completed instruction; timeouts and illegal ops never
  // reach one of these.
  assign retire = (state == ST_MEMWB)  || (state == ST_ALUWB_R) ||
                  (state == ST_ALUWB_I) || (state == ST_BRANCH) ||
                  (state == ST_JUMP)   || (state == ST_JAL) ||
                  ((state == ST_MEMWR) && bus.mem_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire && !(&retired_q)) retired_q <= retired_q + 1'b1;
      if (waiting && !(&stall_q))  stall_q   <= stall_q + 1'b1;
    end
  end

  assign bus.retired_count = retired_q;
  assign bus.stall_count   = stall_q;
`else
  assign bus.retired_count = '0;
  assign bus.stall_count   = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
// Drives opcode/mem_ready, models each instruction as a list of abstract
// steps with a wait-cycle count, and compares every control output and the
// counters on every cycle; a few directed instructions pin literal values.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;
  localparam int WL = 4;
  localparam int CW = 32;
`ifdef MC_CTRL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam int S_F = 0, S_D = 1, S_A = 2, S_RD = 3, S_WB = 4, S_WR = 5,
                 S_XR = 6, S_WBR = 7, S_BR = 8, S_J = 9, S_JL = 10,
                 S_XI = 11, S_WBI = 12;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic [1:0] regdst;
    logic       memread;
    logic       memwrite;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       regwrite;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       pcwbeq;
    logic       pcwbne;
    logic       illegal;
    logic       timeout;
  } ctl_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.CNT_W(CW)) bus();

  mc_control_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int checks = 0;
  int failures = 0;

  int         steps[$];
  logic [5:0] op_q[$];
  bit         ready_q[$];
  logic [5:0] cur_op = 6'h00;
  int         waitc = 0;
  bit         need_new = 1'b1;
  longint     retired_m = 0;
  longint     stalls_m = 0;
  int         done_cnt = 0, cur_len = 0, last_len = 0, last_end = 0;
  logic       cap_beq = 1'b0, cap_bne = 1'b0, cap_ill = 1'b0;
  logic [2:0] cap_aluop = 3'd0;
  logic [1:0] cap_regdst = 2'd0, cap_m2r = 2'd0;
  int         cap_to = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03,
                      6'h08, 6'h0c, 6'h0d, 6'h0a};
  endfunction

  function automatic logic [2:0] imm_op(input logic [5:0] op);
    if (op == 6'h0c) return 3'b011;
    if (op == 6'h0d) return 3'b100;
    if (op == 6'h0a) return 3'b101;
    return 3'b000;
  endfunction

  function automatic ctl_t expect_ctl(input int st, input logic [5:0] op, input bit mr,
                                      input bit to, input bit ill);
    ctl_t c;
    c = '0;
    case (st)
      S_F:   begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
      S_D:   c.alusrcb = 2'b11;
      S_A:   begin c.alusrca = 1; c.alusrcb = 2'b10; end
      S_RD:  begin c.iord = 1; c.memread = 1; end
      S_WB:  begin c.memtoreg = 2'b01; c.regwrite = 1; end
      S_WR:  begin c.iord = 1; c.memwrite = 1; end
      S_XR:  begin c.alusrca = 1; c.aluop = 3'b010; end
      S_WBR: begin c.regdst = 2'b01; c.regwrite = 1; end
      S_BR:  begin
        c.alusrca = 1; c.aluop = 3'b001; c.pcsource = 2'b01;
        c.pcwbeq = (op == 6'h04); c.pcwbne = (op == 6'h05);
      end
      S_J:   begin c.pcsource = 2'b10; c.pcwrite = 1; end
      S_JL:  begin
        c.pcsource = 2'b10; c.pcwrite = 1; c.regdst = 2'b10;
        c.memtoreg = 2'b10; c.regwrite = 1;
      end
      S_XI:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = imm_op(op); end
      S_WBI: begin c.regwrite = 1; c.aluop = imm_op(op); end
      default: c = '0;
    endcase
    c.timeout = to;
    c.illegal = ill;
    return c;
  endfunction

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c.iord = bus.IorD;         c.irwrite = bus.IRWrite;   c.regdst = bus.RegDst;
    c.memread = bus.MemRead;   c.memwrite = bus.MemWrite; c.memtoreg = bus.MemToReg;
    c.alusrca = bus.ALUSrcA;   c.alusrcb = bus.ALUSrcB;   c.aluop = bus.ALUOp;
    c.regwrite = bus.RegWrite; c.pcsource = bus.PCSource; c.pcwrite = bus.PCWrite;
    c.pcwbeq = bus.PCWriteBeq; c.pcwbne = bus.PCWriteBne; c.illegal = bus.illegal_op;
    c.timeout = bus.mem_timeout;
    return c;
  endfunction

  task automatic pick_instr();
    logic [5:0] op;
    if (op_q.size() > 0) begin
      op = op_q.pop_front();
    end else begin
      case ($urandom_range(0, 12))
        0: op = 6'h00;  1: op = 6'h23;  2: op = 6'h2b;  3: op = 6'h04;
        4: op = 6'h05;  5: op = 6'h02;  6: op = 6'h03;  7: op = 6'h08;
        8: op = 6'h0c;  9: op = 6'h0d; 10: op = 6'h0a;
        default: op = 6'($urandom_range(0, 63));
      endcase
    end
    cur_op = op;
    steps.delete();
    steps.push_back(S_F);
    steps.push_back(S_D);
    case (op)
      6'h00: begin steps.push_back(S_XR); steps.push_back(S_WBR); end
      6'h23: begin steps.push_back(S_A); steps.push_back(S_RD); steps.push_back(S_WB); end
      6'h2b: begin steps.push_back(S_A); steps.push_back(S_WR); end
      6'h04, 6'h05: steps.push_back(S_BR);
      6'h02: steps.push_back(S_J);
      6'h03: steps.push_back(S_JL);
      6'h08, 6'h0c, 6'h0d, 6'h0a: begin steps.push_back(S_XI); steps.push_back(S_WBI); end
      default: ;
    endcase
    cur_len = 0;
    waitc = 0;
    need_new = 1'b0;
  endtask

  task automatic finish_instr(input int kind);
    done_cnt++;
    last_len = cur_len;
    last_end = kind;
    need_new = 1'b1;
  endtask

  task automatic run_cycle();
    int cur;
    bit mr, memst, to, ill;
    @(negedge clk);
    if (need_new) pick_instr();
    bus.opcode = cur_op;
    if (ready_q.size() > 0) mr = ready_q.pop_front();
    else mr = ($urandom_range(0, 9) < 6);
    bus.mem_ready = mr;
    #1;
    cur   = steps[0];
    memst = (cur == S_F) || (cur == S_RD) || (cur == S_WR);
    to    = (WL != 0) && memst && !mr && (waitc == WL - 1);
    ill   = (cur == S_D) && !legal(cur_op);
    check("ctl", 64'(dut_ctl()), 64'(expect_ctl(cur, cur_op, mr, to, ill)));
    check("retired_count", 64'(bus.retired_count), 64'((PERF != 0) ? retired_m : 0));
    check("stall_count", 64'(bus.stall_count), 64'((PERF != 0) ? stalls_m : 0));
    if (cur == S_BR) begin cap_beq = bus.PCWriteBeq; cap_bne = bus.PCWriteBne; cap_aluop = bus.ALUOp; end
    if (cur == S_JL) begin cap_regdst = bus.RegDst; cap_m2r = bus.MemToReg; end
    if (cur == S_D)  cap_ill = bus.illegal_op;
    cur_len++;
    if (memst && !mr) stalls_m++;
    if (to) begin
      cap_to = cur_len;
      finish_instr(2);
    end else if (memst && !mr) begin
      waitc++;
    end else begin
      waitc = 0;
      if (ill) begin
        finish_instr(1);
      end else begin
        void'(steps.pop_front());
        if (steps.size() == 0) begin
          retired_m++;
          finish_instr(0);
        end
      end
    end
  endtask

  task automatic run_instr();
    int n0 = done_cnt;
    int k = 0;
    while (done_cnt == n0 && k < 200) begin
      run_cycle();
      k++;
    end
    check("instr_bound", 64'(done_cnt != n0), 64'd1);
  endtask

  task automatic do_reset();
    bit mr;
    @(negedge clk);
    reset_n = 1'b0;
    mr = 1'($urandom_range(0, 1));
    bus.mem_ready = mr;
    #1;
    check("rst_ctl", 64'(dut_ctl()), 64'(expect_ctl(S_F, cur_op, mr, 1'b0, 1'b0)));
    check("rst_memread", 64'(bus.MemRead), 64'd1);
    check("rst_alusrcb", 64'(bus.ALUSrcB), 64'd1);
    check("rst_irwrite", 64'(bus.IRWrite), 64'(mr));
    check("rst_retired", 64'(bus.retired_count), 64'd0);
    check("rst_stall", 64'(bus.stall_count), 64'd0);
    retired_m = 0;
    stalls_m  = 0;
    waitc     = 0;
    need_new  = 1'b1;
    steps.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic check_counters(input string n, input longint r, input longint s);
    @(posedge clk);
    #1;
    check({n, "_retired"}, 64'(bus.retired_count), 64'((PERF != 0) ? r : 0));
    check({n, "_stall"}, 64'(bus.stall_count), 64'((PERF != 0) ? s : 0));
  endtask

  task automatic push_ready(input int n, input bit v);
    for (int i = 0; i < n; i++) ready_q.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;
    do_reset();

    // add, no waits: 4 cycles, retires
    op_q.push_back(6'h00); push_ready(4, 1'b1);
    run_instr();
    check("add_len", 64'(last_len), 64'd4);
    check("add_end", 64'(last_end), 64'd0);
    check_counters("add", 1, 0);

    // lw with 3 waits in MEMRD: 8 cycles, 3 stalls
    op_q.push_back(6'h23);
    push_ready(3, 1'b1); push_ready(3, 1'b0); push_ready(2, 1'b1);
    run_instr();
    check("lw_len", 64'(last_len), 64'd8);
    check("lw_end", 64'(last_end), 64'd0);
    check_counters("lw", 2, 3);

    // FETCH never ready: timeout in the 4th wait cycle, nothing retires
    op_q.push_back(6'h00); push_ready(4, 1'b0);
    run_instr();
    check("to_end", 64'(last_end), 64'd2);
    check("to_cycle", 64'(cap_to), 64'd4);
    check_counters("to", 2, 7);

    // bne then beq
    op_q.push_back(6'h05); push_ready(3, 1'b1);
    run_instr();
    check("bne_len", 64'(last_len), 64'd3);
    check("bne_pcwbne", 64'(cap_bne), 64'd1);
    check("bne_pcwbeq", 64'(cap_beq), 64'd0);
    check("bne_aluop", 64'(cap_aluop), 64'd1);
    op_q.push_back(6'h04); push_ready(3, 1'b1);
    run_instr();
    check("beq_pcwbne", 64'(cap_bne), 64'd0);
    check("beq_pcwbeq", 64'(cap_beq), 64'd1);

    // jal
    op_q.push_back(6'h03); push_ready(3, 1'b1);
    run_instr();
    check("jal_len", 64'(last_len), 64'd3);
    check("jal_regdst", 64'(cap_regdst), 64'd2);
    check("jal_memtoreg", 64'(cap_m2r), 64'd2);

    // sw, no waits: 4 cycles
    op_q.push_back(6'h2b); push_ready(4, 1'b1);
    run_instr();
    check("sw_len", 64'(last_len), 64'd4);

    // illegal opcode, then reset during MEMRD of a lw
    op_q.push_back(6'h3f); push_ready(2, 1'b1);
    run_instr();
    check("ill_end", 64'(last_end), 64'd1);
    check("ill_len", 64'(last_len), 64'd2);
    check("ill_pulse", 64'(cap_ill), 64'd1);
    op_q.push_back(6'h23); push_ready(3, 1'b1); push_ready(2, 1'b0);
    for (int i = 0; i < 5; i++) run_cycle();
    do_reset();

    // sw timing out in MEMWR
    op_q.push_back(6'h2b); push_ready(3, 1'b1); push_ready(4, 1'b0);
    run_instr();
    check("swto_end", 64'(last_end), 64'd2);
    check("swto_len", 64'(last_len), 64'd7);
    check_counters("swto", 0, 4);

    // randomized instruction stream
    for (int n = 0; n < 600; n++) run_instr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multicycle MIPS control unit: the successor to the fixed single-FSM controller. It adds a memory ready/wait handshake with a timeout and BNE/JAL/ANDI/ORI/SLTI support. It also reports illegal opcodes, with optional performance counters. It sits between the instruction register opcode field and the multicycle datapath muxes/enables.

## Interface
Parameters:
- WAIT_LIMIT, 16: max consecutive wait cycles in a memory state before timeout; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- mem_ready  in  1  memory completes the current access this cycle.
- IorD  out  1  address mux: 0 PC, 1 ALUOut.
- IRWrite  out  1  IR load.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemRead, MemWrite  out  1 each  memory strobes.
- MemToReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- ALUSrcA  out  1  0 PC, 1 A.
- ALUSrcB  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2.
- ALUOp  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt.
- RegWrite  out  1  register file write.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- PCWrite, PCWriteBeq, PCWriteBne  out  1 each  PC enables; the conditional enables are qualified by Zero in the datapath.
- illegal_op  out  1  one-cycle pulse in DECODE for an unknown opcode.
- mem_timeout  out  1  one-cycle pulse when a wait limit expires.
- retired_count, stall_count  out  CNT_W each  performance counters.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB_R, BRANCH, JUMP, JAL, EXEC_I, ALUWB_I.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: MemRead=1, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=mem_ready (Mealy).
  - Stays in FETCH while mem_ready=0, else goes to DECODE.
- DECODE:
  - Outputs: ALUSrcB=11, ALUOp=000.
  - Next state by opcode: 0x00 EXEC_R; 0x23/0x2b MEMADR; 0x04/0x05 BRANCH; 0x02 JUMP; 0x03 JAL; 0x08/0x0c/0x0d/0x0a EXEC_I.
  - Any other opcode: illegal_op=1 and next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; goes to MEMRD (0x23) or MEMWR (0x2b).
- MEMRD: IorD=1, MemRead=1; waits for mem_ready, then goes to MEMWB.
- MEMWB: RegDst=00, MemToReg=01, RegWrite=1; goes to FETCH.
- MEMWR: IorD=1, MemWrite=1; waits for mem_ready, then goes to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=010; goes to ALUWB_R.
- ALUWB_R: RegDst=01, RegWrite=1; goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01; PCWriteBeq=1 for 0x04, PCWriteBne=1 for 0x05; goes to FETCH.
- JUMP: PCSource=10, PCWrite=1; goes to FETCH.
- JAL: PCSource=10, PCWrite=1, RegDst=10, MemToReg=10, RegWrite=1 (the PC already holds PC+4); goes to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10; ALUOp 000 (addi), 011 (andi), 100 (ori), 101 (slti); goes to ALUWB_I.
  - andi/ori use the sign-extended immediate; zero extension is the datapath's concern.
- ALUWB_I: RegDst=00, MemToReg=00, RegWrite=1; ALUOp is held from EXEC_I; goes to FETCH.
- opcode is sampled in every state; the IR is stable after FETCH completes.
- Wait timer (memory states only: FETCH, MEMRD, MEMWR):
  - Counts consecutive cycles with mem_ready=0 and clears on any state change.
  - Timeout fires when the count equals WAIT_LIMIT−1 and mem_ready is still 0. Then mem_timeout=1, the next state is FETCH, and the instruction is abandoned with no register write.
  - mem_ready=1 in the limit cycle wins over the timeout.

## Timing
- Reset (reset_n=0): state goes to FETCH immediately.
  - Wait timer and counters clear.
  - Combinational outputs follow FETCH with mem_ready gating (MemRead=1, ALUSrcB=01; IRWrite/PCWrite equal mem_ready).
  - illegal_op=0, mem_timeout=0.
- Reset mid-instruction abandons that instruction.
- Latency with mem_ready tied to 1:
  - R-type and I-type ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne/j/jal: 3 cycles.
- Each wait cycle adds one cycle.
- Counters (when enabled):
  - retired_count increments on the final cycle of every completed instruction, not on illegal or timed-out ones.
  - stall_count increments on every memory-state cycle with mem_ready=0.
  - Both saturate at all-ones.

## Configuration
- MC_CTRL_PERF_EN defined: retired_count and stall_count are implemented as above.
- Not defined: both ports are still present, tied to 0, and no counter flops are generated.

## Structure
- Package mc_ctrl_pkg holds:
  - opcode constants;
  - the state enum (4 bits);
  - ALUOp, RegDst, MemToReg, ALUSrcB and PCSource encodings.
- Sub-module mc_wait_timer (parameter WAIT_LIMIT; inputs clear, waiting; output expired) implements the timeout counter, sized $clog2(WAIT_LIMIT+1).

## Test plan
- add (opcode 0x00), mem_ready=1 → FETCH, DECODE, EXEC_R, ALUWB_R. RegWrite=1 and RegDst=01 in cycle 4. retired_count=1.
- lw (0x23), mem_ready low for 3 cycles in MEMRD → 8-cycle instruction; MemRead and IorD held. stall_count=3. RegWrite only in MEMWB.
- WAIT_LIMIT=4, mem_ready=0 throughout FETCH → mem_timeout pulses in the 4th cycle. Returns to FETCH with no IRWrite. retired_count unchanged.
- bne (0x05) then beq (0x04) → in BRANCH only PCWriteBne=1, then only PCWriteBeq=1. ALUOp=001.
- jal (0x03) → JAL cycle drives RegDst=10, MemToReg=10, RegWrite=1, PCWrite=1, PCSource=10.
- opcode 0x3f, then reset_n pulled low during MEMRD of a following lw → illegal_op pulse in DECODE. On reset, state goes to FETCH immediately and the counters read 0.
